// File: rtl/exec_result_pipe.sv
// exec_result_pipe: per-pipe result tracking shift register.
// Tracks up to seven in-flight instructions and publishes each stage's
// destination, write-enable, latency and landed result for the forwarding
// logic. An instruction leaving stage 7 with its result is written back
// one edge later through the register-file write port.
module exec_result_pipe #(
  parameter int NUM_STAGES  = 7,
  parameter int FLUSH_DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [6:0]   in_reg_dst,
  input  logic         in_reg_wr,
  input  logic [3:0]   in_latency,
  input  logic         res_valid,
  input  logic [3:0]   res_latency,
  input  logic [127:0] res_data,
  input  logic         flush,
  output logic [6:0]   reg_dst_1stage,
  output logic [6:0]   reg_dst_2stage,
  output logic [6:0]   reg_dst_3stage,
  output logic [6:0]   reg_dst_4stage,
  output logic [6:0]   reg_dst_5stage,
  output logic [6:0]   reg_dst_6stage,
  output logic [6:0]   reg_dst_7stage,
  output logic         reg_wr_1stage,
  output logic         reg_wr_2stage,
  output logic         reg_wr_3stage,
  output logic         reg_wr_4stage,
  output logic         reg_wr_5stage,
  output logic         reg_wr_6stage,
  output logic         reg_wr_7stage,
  output logic [3:0]   latency_1stage,
  output logic [3:0]   latency_2stage,
  output logic [3:0]   latency_3stage,
  output logic [3:0]   latency_4stage,
  output logic [3:0]   latency_5stage,
  output logic [3:0]   latency_6stage,
  output logic [3:0]   latency_7stage,
  output logic [127:0] reg_dst_result_1stage,
  output logic [127:0] reg_dst_result_2stage,
  output logic [127:0] reg_dst_result_3stage,
  output logic [127:0] reg_dst_result_4stage,
  output logic [127:0] reg_dst_result_5stage,
  output logic [127:0] reg_dst_result_6stage,
  output logic [127:0] reg_dst_result_7stage,
  output logic         reg_write_en,
  output logic [6:0]   reg_write_addr,
  output logic [127:0] reg_write_data,
  output logic         err
);

  logic         valid_q [1:NUM_STAGES];
  logic [6:0]   dst_q   [1:NUM_STAGES];
  logic         wr_q    [1:NUM_STAGES];
  logic [3:0]   lat_q   [1:NUM_STAGES];
  logic [127:0] data_q  [1:NUM_STAGES];
  logic         ready_q [1:NUM_STAGES];

  logic         valid_n [1:NUM_STAGES];
  logic [6:0]   dst_n   [1:NUM_STAGES];
  logic         wr_n    [1:NUM_STAGES];
  logic [3:0]   lat_n   [1:NUM_STAGES];
  logic [127:0] data_n  [1:NUM_STAGES];
  logic         ready_n [1:NUM_STAGES];

  logic in_lat_ok;
  logic res_lat_ok;
  logic target_pre_valid;
  logic err_set;

  // Next stage contents: shift, kill the flushed stages, land a result, flag protocol errors
  always_comb begin
    in_lat_ok        = (in_latency != 4'd0) && (in_latency <= 4'd7);
    res_lat_ok       = (res_latency != 4'd0) && (res_latency <= 4'd7);
    err_set          = 1'b0;
    target_pre_valid = 1'b0;

    valid_n[1] = in_valid;
    dst_n[1]   = in_valid ? in_reg_dst : 7'd0;
    wr_n[1]    = in_valid & in_reg_wr & in_lat_ok;
    lat_n[1]   = in_valid ? in_latency : 4'd0;
    data_n[1]  = '0;
    ready_n[1] = 1'b0;
    for (int k = 2; k <= NUM_STAGES; k++) begin
      valid_n[k] = valid_q[k-1];
      dst_n[k]   = dst_q[k-1];
      wr_n[k]    = wr_q[k-1];
      lat_n[k]   = lat_q[k-1];
      data_n[k]  = data_q[k-1];
      ready_n[k] = ready_q[k-1];
    end

    for (int k = 1; k <= NUM_STAGES; k++) begin
      if (res_latency == 4'(k)) target_pre_valid = valid_n[k];
    end

    if (flush) begin
      for (int k = 1; k <= FLUSH_DEPTH; k++) begin
        valid_n[k] = 1'b0;
        dst_n[k]   = 7'd0;
        wr_n[k]    = 1'b0;
        lat_n[k]   = 4'd0;
        data_n[k]  = '0;
        ready_n[k] = 1'b0;
      end
    end

    if (in_valid && !in_lat_ok) err_set = 1'b1;

    if (res_valid) begin
      if (!res_lat_ok) begin
        err_set = 1'b1;
      end else if (flush && (res_latency <= 4'(FLUSH_DEPTH))) begin
        if (!target_pre_valid) err_set = 1'b1;
      end else begin
        for (int k = 1; k <= NUM_STAGES; k++) begin
          if (res_latency == 4'(k)) begin
            if (valid_n[k] && (lat_n[k] == res_latency)) begin
              data_n[k]  = res_data;
              ready_n[k] = 1'b1;
            end else begin
              err_set = 1'b1;
            end
          end
        end
      end
    end

    if (valid_q[NUM_STAGES] && wr_q[NUM_STAGES] && !ready_q[NUM_STAGES]) err_set = 1'b1;
  end

  // Stage registers advance every edge; reset empties the whole pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        valid_q[k] <= 1'b0;
        dst_q[k]   <= 7'd0;
        wr_q[k]    <= 1'b0;
        lat_q[k]   <= 4'd0;
        data_q[k]  <= '0;
        ready_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        valid_q[k] <= valid_n[k];
        dst_q[k]   <= dst_n[k];
        wr_q[k]    <= wr_n[k];
        lat_q[k]   <= lat_n[k];
        data_q[k]  <= data_n[k];
        ready_q[k] <= ready_n[k];
      end
    end
  end

  // Register-file write of the instruction retiring from the last stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_en   <= 1'b0;
      reg_write_addr <= 7'd0;
      reg_write_data <= '0;
    end else if (valid_q[NUM_STAGES] && wr_q[NUM_STAGES] && ready_q[NUM_STAGES]) begin
      reg_write_en   <= 1'b1;
      reg_write_addr <= dst_q[NUM_STAGES];
      reg_write_data <= data_q[NUM_STAGES];
    end else begin
      reg_write_en   <= 1'b0;
      reg_write_addr <= 7'd0;
      reg_write_data <= '0;
    end
  end

  // Sticky protocol-error flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  assign reg_dst_1stage = dst_q[1];
  assign reg_dst_2stage = dst_q[2];
  assign reg_dst_3stage = dst_q[3];
  assign reg_dst_4stage = dst_q[4];
  assign reg_dst_5stage = dst_q[5];
  assign reg_dst_6stage = dst_q[6];
  assign reg_dst_7stage = dst_q[7];

  assign reg_wr_1stage = valid_q[1] & wr_q[1];
  assign reg_wr_2stage = valid_q[2] & wr_q[2];
  assign reg_wr_3stage = valid_q[3] & wr_q[3];
  assign reg_wr_4stage = valid_q[4] & wr_q[4];
  assign reg_wr_5stage = valid_q[5] & wr_q[5];
  assign reg_wr_6stage = valid_q[6] & wr_q[6];
  assign reg_wr_7stage = valid_q[7] & wr_q[7];

  assign latency_1stage = lat_q[1];
  assign latency_2stage = lat_q[2];
  assign latency_3stage = lat_q[3];
  assign latency_4stage = lat_q[4];
  assign latency_5stage = lat_q[5];
  assign latency_6stage = lat_q[6];
  assign latency_7stage = lat_q[7];

  assign reg_dst_result_1stage = data_q[1];
  assign reg_dst_result_2stage = data_q[2];
  assign reg_dst_result_3stage = data_q[3];
  assign reg_dst_result_4stage = data_q[4];
  assign reg_dst_result_5stage = data_q[5];
  assign reg_dst_result_6stage = data_q[6];
  assign reg_dst_result_7stage = data_q[7];

endmodule

// File: tb/tb_exec_result_pipe.sv
// tb_exec_result_pipe: directed bench for exec_result_pipe (FLUSH_DEPTH = 3).
module tb_exec_result_pipe;

  localparam int FD = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [6:0]   in_reg_dst;
  logic         in_reg_wr;
  logic [3:0]   in_latency;
  logic         res_valid;
  logic [3:0]   res_latency;
  logic [127:0] res_data;
  logic         flush;

  wire [6:0]   dst_s [1:7];
  wire         wr_s  [1:7];
  wire [3:0]   lat_s [1:7];
  wire [127:0] res_s [1:7];
  wire         reg_write_en;
  wire [6:0]   reg_write_addr;
  wire [127:0] reg_write_data;
  wire         err;
  wire [6:0]   wr_all = {wr_s[7], wr_s[6], wr_s[5], wr_s[4], wr_s[3], wr_s[2], wr_s[1]};

  int checks = 0;
  int failures = 0;

  exec_result_pipe #(.NUM_STAGES(7), .FLUSH_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_reg_dst(in_reg_dst), .in_reg_wr(in_reg_wr), .in_latency(in_latency),
    .res_valid(res_valid), .res_latency(res_latency), .res_data(res_data), .flush(flush),
    .reg_dst_1stage(dst_s[1]), .reg_dst_2stage(dst_s[2]), .reg_dst_3stage(dst_s[3]),
    .reg_dst_4stage(dst_s[4]), .reg_dst_5stage(dst_s[5]), .reg_dst_6stage(dst_s[6]),
    .reg_dst_7stage(dst_s[7]),
    .reg_wr_1stage(wr_s[1]), .reg_wr_2stage(wr_s[2]), .reg_wr_3stage(wr_s[3]),
    .reg_wr_4stage(wr_s[4]), .reg_wr_5stage(wr_s[5]), .reg_wr_6stage(wr_s[6]),
    .reg_wr_7stage(wr_s[7]),
    .latency_1stage(lat_s[1]), .latency_2stage(lat_s[2]), .latency_3stage(lat_s[3]),
    .latency_4stage(lat_s[4]), .latency_5stage(lat_s[5]), .latency_6stage(lat_s[6]),
    .latency_7stage(lat_s[7]),
    .reg_dst_result_1stage(res_s[1]), .reg_dst_result_2stage(res_s[2]),
    .reg_dst_result_3stage(res_s[3]), .reg_dst_result_4stage(res_s[4]),
    .reg_dst_result_5stage(res_s[5]), .reg_dst_result_6stage(res_s[6]),
    .reg_dst_result_7stage(res_s[7]),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data), .err(err)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  function automatic logic [127:0] d(input int i);
    return {4{32'hD00D_0000 + 32'(i)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_reg_dst = 7'd0; in_reg_wr = 1'b0; in_latency = 4'd0;
    res_valid = 1'b0; res_latency = 4'd0; res_data = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (dst_s[k] !== 7'd0 || wr_s[k] !== 1'b0 || lat_s[k] !== 4'd0 || res_s[k] !== 128'd0) begin
        failures++;
        $display("[TB] FAIL reset_stage%0d got dst=%0h wr=%0b lat=%0h res=%0h expected all 0", k, dst_s[k], wr_s[k], lat_s[k], res_s[k]);
      end
    end
    checks++;
    if (reg_write_en !== 1'b0 || reg_write_addr !== 7'd0 || reg_write_data !== 128'd0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_wb got en=%0b addr=%0h data=%0h err=%0b expected all 0", reg_write_en, reg_write_addr, reg_write_data, err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_reg_dst = 7'd5; in_reg_wr = 1'b1; in_latency = 4'd2;
    tick();
    checks++;
    if (dst_s[1] !== 7'd5 || wr_s[1] !== 1'b1 || lat_s[1] !== 4'd2 || res_s[1] !== 128'd0) begin
      failures++;
      $display("[TB] FAIL basic_stage1 got dst=%0h wr=%0b lat=%0h res=%0h expected 5/1/2/0", dst_s[1], wr_s[1], lat_s[1], res_s[1]);
    end
    idle();
    res_valid = 1'b1; res_latency = 4'd2; res_data = {16{8'hAA}};
    tick();
    checks++;
    if (dst_s[2] !== 7'd5 || res_s[2] !== {16{8'hAA}}) begin
      failures++;
      $display("[TB] FAIL basic_stage2 got dst=%0h res=%0h expected 5/%0h", dst_s[2], res_s[2], {16{8'hAA}});
    end
    idle();
    for (int e = 2; e <= 6; e++) begin
      tick();
      checks++;
      if (reg_write_en !== 1'b0) begin
        failures++;
        $display("[TB] FAIL basic_early_wb edge%0d got en=%0b expected 0", e, reg_write_en);
      end
    end
    tick();
    checks++;
    if (reg_write_en !== 1'b1 || reg_write_addr !== 7'd5 || reg_write_data !== {16{8'hAA}} || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_wb got en=%0b addr=%0h data=%0h err=%0b expected 1/5/aa..aa/0", reg_write_en, reg_write_addr, reg_write_data, err);
    end
    tick();
    checks++;
    if (reg_write_en !== 1'b0 || reg_write_addr !== 7'd0 || reg_write_data !== 128'd0) begin
      failures++;
      $display("[TB] FAIL basic_wb_pulse got en=%0b addr=%0h data=%0h expected 0/0/0", reg_write_en, reg_write_addr, reg_write_data);
    end
  endtask

  task automatic test_back_to_back();
    logic         exp_en;
    logic [6:0]   exp_addr;
    logic [127:0] exp_data;
    for (int t = 0; t <= 14; t++) begin
      idle();
      if (t < 7) begin
        in_valid = 1'b1; in_reg_dst = 7'(10 + t); in_reg_wr = 1'b1; in_latency = 4'(t + 1);
      end
      if ((t % 2) == 0 && t <= 12) begin
        res_valid = 1'b1; res_latency = 4'(t / 2 + 1); res_data = d(t / 2);
      end
      tick();
      if (t >= 7 && t <= 13) begin
        exp_en = 1'b1; exp_addr = 7'(10 + t - 7); exp_data = d(t - 7);
      end else begin
        exp_en = 1'b0; exp_addr = 7'd0; exp_data = '0;
      end
      checks++;
      if (reg_write_en !== exp_en || reg_write_addr !== exp_addr || reg_write_data !== exp_data) begin
        failures++;
        $display("[TB] FAIL b2b_wb edge%0d got en=%0b addr=%0h data=%0h expected %0b/%0h/%0h", t, reg_write_en, reg_write_addr, reg_write_data, exp_en, exp_addr, exp_data);
      end
    end
    idle();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_err got %0b expected 0", err);
    end
  endtask

  task automatic test_no_write();
    in_valid = 1'b1; in_reg_dst = 7'd9; in_reg_wr = 1'b0; in_latency = 4'd1;
    res_valid = 1'b1; res_latency = 4'd1; res_data = d(99);
    tick();
    checks++;
    if (dst_s[1] !== 7'd9 || wr_s[1] !== 1'b0 || res_s[1] !== d(99)) begin
      failures++;
      $display("[TB] FAIL nowr_stage1 got dst=%0h wr=%0b res=%0h expected 9/0/%0h", dst_s[1], wr_s[1], res_s[1], d(99));
    end
    idle();
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (wr_all !== 7'd0 || reg_write_en !== 1'b0) begin
        failures++;
        $display("[TB] FAIL nowr_edge%0d got wr=%0b en=%0b expected 0/0", e, wr_all, reg_write_en);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nowr_err got %0b expected 0", err);
    end
  endtask

  task automatic test_flush();
    logic [6:0]   exp_dst [1:7];
    logic         exp_en;
    logic [6:0]   exp_addr;
    for (int t = 0; t <= 3; t++) begin
      idle();
      in_valid = 1'b1; in_reg_dst = 7'(20 + t); in_reg_wr = 1'b1; in_latency = 4'd1;
      res_valid = 1'b1; res_latency = 4'd1; res_data = d(20 + t);
      tick();
    end
    idle();
    in_valid = 1'b1; in_reg_dst = 7'd24; in_reg_wr = 1'b1; in_latency = 4'd2;
    tick();
    idle();
    flush = 1'b1;
    in_valid = 1'b1; in_reg_dst = 7'd25; in_reg_wr = 1'b1; in_latency = 4'd1;
    res_valid = 1'b1; res_latency = 4'd2; res_data = d(24);
    tick();
    idle();
    exp_dst[1] = 7'd0;  exp_dst[2] = 7'd0;  exp_dst[3] = 7'd0;  exp_dst[4] = 7'd22;
    exp_dst[5] = 7'd21; exp_dst[6] = 7'd20; exp_dst[7] = 7'd0;
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (dst_s[k] !== exp_dst[k] || wr_s[k] !== (exp_dst[k] != 7'd0) ||
          lat_s[k] !== ((exp_dst[k] != 7'd0) ? 4'd1 : 4'd0) ||
          res_s[k] !== ((exp_dst[k] != 7'd0) ? d(int'(exp_dst[k])) : 128'd0)) begin
        failures++;
        $display("[TB] FAIL flush_stage%0d got dst=%0h wr=%0b lat=%0h res=%0h expected dst=%0h", k, dst_s[k], wr_s[k], lat_s[k], res_s[k], exp_dst[k]);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_err got %0b expected 0", err);
    end
    for (int t = 6; t <= 12; t++) begin
      tick();
      exp_en = (t >= 7 && t <= 9);
      exp_addr = exp_en ? 7'(20 + t - 7) : 7'd0;
      checks++;
      if (reg_write_en !== exp_en || reg_write_addr !== exp_addr ||
          reg_write_data !== (exp_en ? d(20 + t - 7) : 128'd0)) begin
        failures++;
        $display("[TB] FAIL flush_wb edge%0d got en=%0b addr=%0h data=%0h expected %0b/%0h", t, reg_write_en, reg_write_addr, reg_write_data, exp_en, exp_addr);
      end
    end
  endtask

  task automatic test_bad_latency();
    in_valid = 1'b1; in_reg_dst = 7'd30; in_reg_wr = 1'b1; in_latency = 4'd3;
    tick();
    idle();
    res_valid = 1'b1; res_latency = 4'd2; res_data = d(30);
    tick();
    idle();
    checks++;
    if (err !== 1'b1 || dst_s[2] !== 7'd30 || res_s[2] !== 128'd0) begin
      failures++;
      $display("[TB] FAIL badlat_land got err=%0b dst=%0h res=%0h expected 1/1e/0", err, dst_s[2], res_s[2]);
    end
    for (int e = 2; e <= 8; e++) begin
      tick();
      checks++;
      if (reg_write_en !== 1'b0 || err !== 1'b1) begin
        failures++;
        $display("[TB] FAIL badlat_edge%0d got en=%0b err=%0b expected 0/1", e, reg_write_en, err);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int t = 0; t <= 7; t++) begin
      idle();
      in_valid = 1'b1; in_reg_dst = 7'(40 + t); in_reg_wr = 1'b1; in_latency = 4'd1;
      res_valid = 1'b1; res_latency = 4'd1; res_data = d(40 + t);
      tick();
    end
    idle();
    checks++;
    if (wr_all !== 7'h7f || reg_write_en !== 1'b1 || reg_write_addr !== 7'd40) begin
      failures++;
      $display("[TB] FAIL arst_full got wr=%0h en=%0b addr=%0h expected 7f/1/28", wr_all, reg_write_en, reg_write_addr);
    end
    #3;
    rst = 1'b1;
    #1;
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (dst_s[k] !== 7'd0 || wr_s[k] !== 1'b0 || lat_s[k] !== 4'd0 || res_s[k] !== 128'd0) begin
        failures++;
        $display("[TB] FAIL arst_stage%0d got dst=%0h wr=%0b lat=%0h res=%0h expected all 0", k, dst_s[k], wr_s[k], lat_s[k], res_s[k]);
      end
    end
    checks++;
    if (reg_write_en !== 1'b0 || reg_write_addr !== 7'd0 || reg_write_data !== 128'd0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arst_wb got en=%0b addr=%0h data=%0h err=%0b expected all 0", reg_write_en, reg_write_addr, reg_write_data, err);
    end
    #2;
    rst = 1'b0;
    in_valid = 1'b1; in_reg_dst = 7'd0; in_reg_wr = 1'b1; in_latency = 4'd1;
    res_valid = 1'b1; res_latency = 4'd1; res_data = d(0);
    tick();
    idle();
    checks++;
    if (wr_s[1] !== 1'b1 || lat_s[1] !== 4'd1 || res_s[1] !== d(0)) begin
      failures++;
      $display("[TB] FAIL arst_restart got wr=%0b lat=%0h res=%0h expected 1/1/%0h", wr_s[1], lat_s[1], res_s[1], d(0));
    end
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (reg_write_en !== 1'b0) begin
        failures++;
        $display("[TB] FAIL arst_early_wb edge%0d got en=%0b expected 0", e, reg_write_en);
      end
    end
    tick();
    checks++;
    if (reg_write_en !== 1'b1 || reg_write_addr !== 7'd0 || reg_write_data !== d(0) || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arst_wb_r0 got en=%0b addr=%0h data=%0h err=%0b expected 1/0/%0h/0", reg_write_en, reg_write_addr, reg_write_data, err, d(0));
    end
    tick();
    checks++;
    if (reg_write_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arst_wb_pulse got en=%0b expected 0", reg_write_en);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_no_write();
    test_flush();
    test_bad_latency();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
